key_cmd_scheduler: RTL and testbench

- Sits between the PS/2 keyboard decoder and the dino game engine.
- Turns raw key events (9-bit code plus make/break pulse) and the held-key vector into a queue of game commands, gated by a game-mode FSM (IDLE/RUN/PAUSED).
- Auto-repeats JUMP while the key is held.
- The engine drains commands through a valid/ready handshake, at most one per cycle.

---
 rtl/key_cmd_if.sv | 23 ++
 rtl/key_cmd_scheduler.sv | 144 ++++++++++++++
 tb/tb_key_cmd_scheduler.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/key_cmd_if.sv
// Command-side bundle between the key decoder, the scheduler and the game engine.
interface key_cmd_if;
  logic         key_valid;
  logic [8:0]   last_change;
  logic [511:0] key_down;
  logic         game_over;
  logic         cmd_valid;
  logic [2:0]   cmd;
  logic         cmd_ready;
  logic [1:0]   mode;
  logic         duck_held;
  logic         overflow;

  modport master (
    input  key_valid, last_change, key_down, game_over, cmd_ready,
    output cmd_valid, cmd, mode, duck_held, overflow
  );

  modport slave (
    output key_valid, last_change, key_down, game_over, cmd_ready,
    input  cmd_valid, cmd, mode, duck_held, overflow
  );
endinterface

// File: rtl/key_cmd_scheduler.sv
// Converts keyboard events into queued dino-game commands under an IDLE/RUN/PAUSED
// mode machine, with JUMP auto-repeat while the space bar is held.
module key_cmd_scheduler #(
  parameter logic [8:0] JUMP_CODE     = 9'h029,
  parameter logic [8:0] DUCK_CODE     = 9'h172,
  parameter logic [8:0] START_CODE    = 9'h05A,
  parameter logic [8:0] PAUSE_CODE    = 9'h04D,
  parameter int         FIFO_DEPTH    = 4,
  parameter int         REPEAT_DELAY  = 25_000_000,
  parameter int         REPEAT_PERIOD = 10_000_000
) (
  input  logic      clock,
  input  logic      rst,
  key_cmd_if.master bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(REPEAT_DELAY + 1);
  localparam logic [PTR_W:0]   DEPTH_C    = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] RPT_LAST   = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);

  localparam logic [2:0] CMD_NONE     = 3'd0;
  localparam logic [2:0] CMD_JUMP     = 3'd1;
  localparam logic [2:0] CMD_DUCK_ON  = 3'd2;
  localparam logic [2:0] CMD_DUCK_OFF = 3'd3;
  localparam logic [2:0] CMD_START    = 3'd4;
  localparam logic [2:0] CMD_PAUSE    = 3'd5;
  localparam logic [2:0] CMD_RESUME   = 3'd6;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2} mode_t;

  mode_t            mode_q, mode_d;
  logic             key_make;
  logic [2:0]       key_cmd;
  logic             key_push;
  logic [2:0]       key_push_cmd;
  logic [CNT_W-1:0] rpt_cnt_q;
  logic             rpt_pend_q;
  logic             rpt_active, rpt_req, rpt_want, rpt_push;
  logic             push_req, do_push, pop, full;
  logic [2:0]       push_data;
  logic [2:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             overflow_q;
  logic             duck_q;

  // Stage: classify the incoming key event
  assign key_make = bus.key_down[bus.last_change];

  always_comb begin
    key_cmd = CMD_NONE;
    if (bus.key_valid) begin
      if (bus.last_change == JUMP_CODE) begin
        if (key_make) key_cmd = CMD_JUMP;
      end else if (bus.last_change == DUCK_CODE) begin
        key_cmd = key_make ? CMD_DUCK_ON : CMD_DUCK_OFF;
      end else if (bus.last_change == START_CODE) begin
        if (key_make) key_cmd = CMD_START;
      end else if (bus.last_change == PAUSE_CODE) begin
        if (key_make) key_cmd = CMD_PAUSE;
      end
    end
  end

  // Stage: mode machine decides which key command survives
  always_comb begin
    mode_d       = mode_q;
    key_push     = 1'b0;
    key_push_cmd = CMD_NONE;
    if (bus.game_over) begin
      mode_d = IDLE;
    end else begin
      unique case (mode_q)
        IDLE: if (key_cmd == CMD_START) begin
          mode_d = RUN; key_push = 1'b1; key_push_cmd = CMD_START;
        end
        RUN: if (key_cmd == CMD_PAUSE) begin
          mode_d = PAUSED; key_push = 1'b1; key_push_cmd = CMD_PAUSE;
        end else if (key_cmd == CMD_JUMP || key_cmd == CMD_DUCK_ON || key_cmd == CMD_DUCK_OFF) begin
          key_push = 1'b1; key_push_cmd = key_cmd;
        end
        PAUSED: if (key_cmd == CMD_PAUSE) begin
          mode_d = RUN; key_push = 1'b1; key_push_cmd = CMD_RESUME;
        end
        default: mode_d = IDLE;
      endcase
    end
  end

  // Stage: auto-repeat; a request colliding with a key push waits one cycle as pending
  assign rpt_active = bus.key_down[JUMP_CODE] && (mode_q == RUN);
  assign rpt_req    = rpt_active && (rpt_cnt_q == RPT_LAST);
  assign rpt_want   = rpt_active && (rpt_req || rpt_pend_q);
  assign rpt_push   = rpt_want && !key_push && !bus.game_over;

  assign push_req  = key_push || rpt_push;
  assign push_data = key_push ? key_push_cmd : CMD_JUMP;

  // Stage: command queue
  assign full    = (count == DEPTH_C);
  assign pop     = bus.cmd_valid && bus.cmd_ready;
  assign do_push = push_req && (!full || pop);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      mode_q     <= IDLE;
      rpt_cnt_q  <= '0;
      rpt_pend_q <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
      duck_q     <= 1'b0;
    end else begin
      mode_q <= mode_d;
      duck_q <= bus.key_down[DUCK_CODE];
      if (!rpt_active) begin
        rpt_cnt_q  <= '0;
        rpt_pend_q <= 1'b0;
      end else begin
        rpt_cnt_q  <= rpt_req ? RPT_RELOAD : rpt_cnt_q + 1'b1;
        rpt_pend_q <= rpt_want && !rpt_push;
      end
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !pop)      count <= count + 1'b1;
      else if (pop && !do_push) count <= count - 1'b1;
      if (push_req && full && !pop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign bus.cmd_valid = (count != '0);
  assign bus.cmd       = bus.cmd_valid ? mem[rd_ptr] : CMD_NONE;
  assign bus.mode      = mode_q;
  assign bus.duck_held = duck_q && (mode_q == RUN);
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_key_cmd_scheduler.sv
// Bench for key_cmd_scheduler: queue-based behavioural model, directed scenarios, random traffic.
module tb_key_cmd_scheduler;
  localparam logic [8:0] JUMP  = 9'h029;
  localparam logic [8:0] DUCK  = 9'h172;
  localparam logic [8:0] START = 9'h05A;
  localparam logic [8:0] PAUSE = 9'h04D;
  localparam int DEPTH = 4;
  localparam int RDLY  = 10;
  localparam int RPER  = 4;

  logic clock = 1'b0;
  logic rst   = 1'b0;
  key_cmd_if bus();

  key_cmd_scheduler #(
    .FIFO_DEPTH(DEPTH), .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER)
  ) dut (
    .clock(clock),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int log_cmd[$];
  int log_t[$];
  int t0;

  // model state
  int m_mode;
  int m_q[$];
  bit m_ovf, m_duck, m_pend;
  int m_held;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_q.delete(); m_ovf = 0; m_duck = 0; m_pend = 0; m_held = 0;
  endtask

  task automatic model_step();
    int m, kp, code, pushv;
    bit mk, qual, req, want, rp;
    m = m_mode; kp = 0; code = bus.last_change;
    mk = bus.key_down[bus.last_change];
    if (bus.game_over) m_mode = 0;
    else if (bus.key_valid) begin
      if (m == 0) begin
        if (code == START && mk) begin m_mode = 1; kp = 4; end
      end else if (m == 1) begin
        if (code == PAUSE && mk) begin m_mode = 2; kp = 5; end
        else if (code == JUMP && mk) kp = 1;
        else if (code == DUCK) kp = mk ? 2 : 3;
      end else if (m == 2) begin
        if (code == PAUSE && mk) begin m_mode = 1; kp = 6; end
      end
    end
    qual = bus.key_down[JUMP] && (m == 1);
    if (qual) m_held++; else m_held = 0;
    req  = qual && (m_held >= RDLY) && (((m_held - RDLY) % RPER) == 0);
    want = qual && (req || m_pend);
    rp   = want && (kp == 0) && !bus.game_over;
    m_pend = want && !rp;
    pushv = (kp != 0) ? kp : (rp ? 1 : 0);
    if (m_q.size() > 0 && bus.cmd_ready) void'(m_q.pop_front());
    if (pushv != 0) begin
      if (m_q.size() < DEPTH) m_q.push_back(pushv);
      else m_ovf = 1;
    end
    m_duck = bus.key_down[DUCK];
  endtask

  always @(posedge clock or posedge rst) begin
    if (rst) model_reset();
    else model_step();
  end

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (!rst) begin
      chk("cmd_valid", int'(bus.cmd_valid), (m_q.size() > 0) ? 1 : 0);
      chk("cmd", int'(bus.cmd), (m_q.size() > 0) ? m_q[0] : 0);
      chk("mode", int'(bus.mode), m_mode);
      chk("overflow", int'(bus.overflow), int'(m_ovf));
      chk("duck_held", int'(bus.duck_held), (m_duck && m_mode == 1) ? 1 : 0);
      if (bus.cmd_valid && bus.cmd_ready) begin
        log_cmd.push_back(int'(bus.cmd));
        log_t.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic ev(input logic [8:0] code, input bit mk, input bit go);
    bus.key_down[code] = mk;
    bus.last_change    = code;
    bus.key_valid      = 1'b1;
    bus.game_over      = go;
    tick();
    bus.key_valid = 1'b0;
    bus.game_over = 1'b0;
  endtask

  task automatic press(input logic [8:0] code);
    ev(code, 1'b1, 1'b0);
    bus.key_down[code] = 1'b0;
  endtask

  initial begin
    logic [8:0] codes [5];
    logic [8:0] c;
    int r;
    bus.key_valid = 0; bus.last_change = '0; bus.key_down = '0;
    bus.game_over = 0; bus.cmd_ready = 0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_valid", int'(bus.cmd_valid), 0);
    chk("rst_cmd", int'(bus.cmd), 0);
    chk("rst_mode", int'(bus.mode), 0);
    chk("rst_ovf", int'(bus.overflow), 0);
    chk("rst_duck", int'(bus.duck_held), 0);
    @(posedge clock); #1 rst = 1'b0;
    tick();

    // IDLE drops everything but START
    press(JUMP); press(DUCK); tick();
    chk("idle_valid", int'(bus.cmd_valid), 0);
    chk("idle_mode", int'(bus.mode), 0);

    // START latency, then START/PAUSE/RESUME sequence
    log_cmd.delete(); log_t.delete();
    press(START);
    chk("start_mode", int'(bus.mode), 1);
    chk("start_valid", int'(bus.cmd_valid), 1);
    chk("start_cmd", int'(bus.cmd), 4);
    bus.cmd_ready = 1; tick();
    chk("start_popped", int'(bus.cmd_valid), 0);
    press(PAUSE);
    chk("pause_mode", int'(bus.mode), 2);
    press(JUMP);
    chk("paused_jump_mode", int'(bus.mode), 2);
    press(PAUSE);
    chk("resume_mode", int'(bus.mode), 1);
    tick(); tick();
    chk("seq_len", log_cmd.size(), 3);
    if (log_cmd.size() == 3) begin
      chk("seq0", log_cmd[0], 4); chk("seq1", log_cmd[1], 5); chk("seq2", log_cmd[2], 6);
    end

    // overflow and pop-while-push on a full queue
    bus.cmd_ready = 0;
    repeat (5) press(JUMP);
    chk("ovf_set", int'(bus.overflow), 1);
    chk("ovf_head", int'(bus.cmd), 1);
    bus.cmd_ready = 1; press(JUMP); bus.cmd_ready = 0; tick();
    chk("ovf_sticky", int'(bus.overflow), 1);
    log_cmd.delete(); log_t.delete();
    bus.cmd_ready = 1; repeat (6) tick();
    chk("full_drain_len", log_cmd.size(), 4);

    // auto-repeat cadence
    log_cmd.delete(); log_t.delete();
    t0 = cyc; bus.key_down[JUMP] = 1;
    repeat (30) tick();
    bus.key_down[JUMP] = 0;
    repeat (3) tick();
    chk("rpt_len", log_cmd.size(), 6);
    for (int i = 0; i < 5 && i < log_cmd.size(); i++) begin
      chk("rpt_cmd", log_cmd[i], 1);
      chk("rpt_time", log_t[i] - t0, 10 + 4 * i);
    end

    // DUCK event on a repeat cycle wins, JUMP follows
    log_cmd.delete(); log_t.delete();
    t0 = cyc; bus.key_down[JUMP] = 1;
    repeat (9) tick();
    ev(DUCK, 1'b1, 1'b0);
    repeat (3) tick();
    bus.key_down[JUMP] = 0;
    chk("coll_len", log_cmd.size(), 2);
    if (log_cmd.size() == 2) begin
      chk("coll_first", log_cmd[0], 2); chk("coll_first_t", log_t[0] - t0, 10);
      chk("coll_second", log_cmd[1], 1); chk("coll_second_t", log_t[1] - t0, 11);
    end
    chk("duck_held_on", int'(bus.duck_held), 1);
    ev(DUCK, 1'b0, 1'b0);
    chk("duck_held_off", int'(bus.duck_held), 0);
    tick();
    chk("duck_off_cmd", log_cmd[log_cmd.size() - 1], 3);

    // game_over beats a coincident JUMP, queue retained
    bus.cmd_ready = 0;
    press(JUMP); press(JUMP);
    ev(JUMP, 1'b1, 1'b1); bus.key_down[JUMP] = 0;
    chk("go_mode", int'(bus.mode), 0);
    log_cmd.delete(); log_t.delete();
    bus.cmd_ready = 1; repeat (4) tick();
    chk("go_retained", log_cmd.size(), 2);

    // asynchronous reset with a loaded queue in PAUSED
    bus.cmd_ready = 0;
    press(START); press(JUMP); press(PAUSE);
    chk("pre_rst_mode", int'(bus.mode), 2);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", int'(bus.cmd_valid), 0);
    chk("arst_mode", int'(bus.mode), 0);
    chk("arst_ovf", int'(bus.overflow), 0);
    @(posedge clock); #1 rst = 1'b0;
    tick();

    // random traffic against the model
    codes[0] = JUMP; codes[1] = DUCK; codes[2] = START; codes[3] = PAUSE; codes[4] = 9'h000;
    repeat (2000) begin
      bus.cmd_ready = ($urandom_range(0, 3) != 0);
      bus.key_valid = 1'b0;
      r = $urandom_range(0, 99);
      bus.game_over = (r < 2);
      if (r >= 2 && r < 6) bus.key_down[JUMP] = ~bus.key_down[JUMP];
      if (r >= 60) begin
        c = codes[$urandom_range(0, 4)];
        if (c == 9'h000) c = 9'($urandom_range(0, 511));
        bus.key_down[c] = 1'($urandom_range(0, 1));
        bus.last_change = c;
        bus.key_valid = 1'b1;
      end
      tick();
    end
    bus.key_valid = 0; bus.game_over = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
